// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch display path:
//   - active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}
//   - converter FSM state enum
//   - digit-index type and the index of each display position
//   - MAX_SEG, the largest seconds value that can be shown without saturating
//   - digit_glyph(), which maps a 4-bit digit to its glyph (10..15 -> dash)
// ---------------------------------------------------------------------------
package stopwatch_pkg;

   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   localparam logic [9:0] MAX_SEG = 10'd999;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } conv_state_t;

   typedef logic [1:0] digit_idx_t;

   localparam digit_idx_t IDX_HUND   = 2'd3;
   localparam digit_idx_t IDX_TENS   = 2'd2;
   localparam digit_idx_t IDX_UNITS  = 2'd1;
   localparam digit_idx_t IDX_TENTHS = 2'd0;

   // Anything that is not a decimal digit is shown as a dash.
   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = GLYPH_0;
         4'd1:    g = GLYPH_1;
         4'd2:    g = GLYPH_2;
         4'd3:    g = GLYPH_3;
         4'd4:    g = GLYPH_4;
         4'd5:    g = GLYPH_5;
         4'd6:    g = GLYPH_6;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_8;
         4'd9:    g = GLYPH_9;
         default: g = GLYPH_DASH;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// ---------------------------------------------------------------------------
// stopwatch_display_if
// Groups the counter inputs and the display outputs of stopwatch_display.
//   cont_seg [9:0] : seconds count, binary
//   cont_dec [3:0] : tenths count, binary
//   an       [3:0] : digit enables, active-low one-hot (an[3] = hundreds)
//   seg      [6:0] : segment cathodes, active-low, {g,f,e,d,c,b,a}
//   dp             : decimal point, active-low
//   ovf            : last committed seconds value was above 999
// master = counter/observer side, slave = the display block.
// ---------------------------------------------------------------------------
interface stopwatch_display_if;

   logic [9:0] cont_seg;
   logic [3:0] cont_dec;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       ovf;

   modport master (
      output cont_seg,
      output cont_dec,
      input  an,
      input  seg,
      input  dp,
      input  ovf
   );

   modport slave (
      input  cont_seg,
      input  cont_dec,
      output an,
      output seg,
      output dp,
      output ovf
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Serial shift-add-3 (double dabble) converter, 10-bit binary to 3 BCD digits.
//   clk, reset : clock, asynchronous active-low reset
//   start      : load bin_in and restart a conversion (takes priority)
//   bin_in     : binary value sampled on the start edge
//   bcd_out    : {hundreds, tens, units}; valid the cycle after done
//   done       : high during the last of the 10 iterations
// Only values up to 999 fit in 12 BCD bits; larger inputs give a
// truncated hundreds digit and must be saturated by the caller.
// ---------------------------------------------------------------------------
module bin2bcd_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [9:0]  bin_in,
   output logic [11:0] bcd_out,
   output logic        done
);

   logic [9:0]  bin_q, bin_d;
   logic [11:0] bcd_q, bcd_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [11:0] adj;

   // One iteration per cycle: correct every nibble >= 5, then shift the
   // next binary bit into the BCD accumulator.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end

      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done   = 1'b0;

      if (start) begin
         bin_d  = bin_in;
         bcd_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         {bcd_d, bin_d} = {adj, bin_q} << 1;
         cnt_d          = cnt_q + 4'd1;
         if (cnt_q == 4'd9) begin
            busy_d = 1'b0;
            done   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign bcd_out = bcd_q;

endmodule

// File: rtl/stopwatch_display.sv
// ---------------------------------------------------------------------------
// stopwatch_display
// Snapshots the stopwatch counters, converts seconds to BCD, and drives a
// four-digit multiplexed seven-segment display showing "SSS.d".
//   SCAN_DIV : cycles each digit stays enabled (>= 1)
//   clk      : clock
//   reset    : asynchronous active-low reset
//   bus      : stopwatch_display_if.slave (cont_seg/cont_dec in,
//              an/seg/dp/ovf out, all outputs registered)
// Every 12 cycles: IDLE snapshots the inputs, CONV runs 10 converter
// iterations, COMMIT loads all digit registers and ovf on one edge.
// ---------------------------------------------------------------------------
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int SCAN_DIV = 4
) (
   input  logic               clk,
   input  logic               reset,
   stopwatch_display_if.slave bus
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

   conv_state_t   state_q, state_d;
   logic [3:0]    dec_snap_q, dec_snap_d;
   logic          ovf_snap_q, ovf_snap_d;
   logic [3:0]    hund_q, hund_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    unit_q, unit_d;
   logic [3:0]    tenth_q, tenth_d;
   logic          ovf_q, ovf_d;

   logic [PW-1:0] presc_q, presc_d;
   digit_idx_t    idx_q, idx_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          conv_start;
   logic          conv_done;
   logic [11:0]   bcd;

   bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .reset   (reset),
      .start   (conv_start),
      .bin_in  (bus.cont_seg),
      .bcd_out (bcd),
      .done    (conv_done)
   );

   // The converter latches cont_seg on the same IDLE edge that snapshots
   // the tenths and the overflow flag, so all three belong together.
   always_comb begin
      state_d    = state_q;
      dec_snap_d = dec_snap_q;
      ovf_snap_d = ovf_snap_q;
      hund_d     = hund_q;
      tens_d     = tens_q;
      unit_d     = unit_q;
      tenth_d    = tenth_q;
      ovf_d      = ovf_q;
      conv_start = 1'b0;

      case (state_q)
         IDLE: begin
            conv_start = 1'b1;
            dec_snap_d = bus.cont_dec;
            ovf_snap_d = (bus.cont_seg > MAX_SEG);
            state_d    = CONV;
         end
         CONV: begin
            if (conv_done) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            if (ovf_snap_q) begin
               hund_d = 4'd9;
               tens_d = 4'd9;
               unit_d = 4'd9;
               ovf_d  = 1'b1;
            end else begin
               hund_d = bcd[11:8];
               tens_d = bcd[7:4];
               unit_d = bcd[3:0];
               ovf_d  = 1'b0;
            end
            tenth_d = dec_snap_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         dec_snap_q <= '0;
         ovf_snap_q <= 1'b0;
         hund_q     <= '0;
         tens_q     <= '0;
         unit_q     <= '0;
         tenth_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dec_snap_q <= dec_snap_d;
         ovf_snap_q <= ovf_snap_d;
         hund_q     <= hund_d;
         tens_q     <= tens_d;
         unit_q     <= unit_d;
         tenth_q    <= tenth_d;
         ovf_q      <= ovf_d;
      end
   end

   // Scanner walks 3->2->1->0 (decrement wraps). The outputs are decoded
   // from the current index and digits and registered, so they lag both
   // an index step and a COMMIT by exactly one cycle.
   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         idx_d   = idx_q - 1'b1;
      end

      an_d        = 4'b1111;
      an_d[idx_q] = 1'b0;
      dp_d        = (idx_q == IDX_UNITS) ? 1'b0 : 1'b1;

      seg_d = GLYPH_BLANK;
      case (idx_q)
         IDX_HUND:  seg_d = (hund_q == 4'd0) ? GLYPH_BLANK : digit_glyph(hund_q);
         IDX_TENS:  seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? GLYPH_BLANK
                                                               : digit_glyph(tens_q);
         IDX_UNITS: seg_d = digit_glyph(unit_q);
         default:   seg_d = digit_glyph(tenth_q);
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         idx_q   <= IDX_HUND;
         an_q    <= 4'b1111;
         seg_q   <= GLYPH_BLANK;
         dp_q    <= 1'b1;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
   assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_display
// Directed bench for stopwatch_display: one SCAN_DIV=4 instance under full
// test, plus a SCAN_DIV=1 instance sharing its inputs for the fast-scan case.
// ---------------------------------------------------------------------------
module tb_stopwatch_display;

   localparam int SCAN_DIV = 4;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   logic clk = 1'b0;
   logic reset = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;
   int edge_cnt     = 0;

   logic [6:0] scan_seg [4];
   logic       scan_dp [4];
   int         scan_hold [4];
   bit         scan_ok;

   stopwatch_display_if bus ();
   stopwatch_display_if bus1 ();

   assign bus1.cont_seg = bus.cont_seg;
   assign bus1.cont_dec = bus.cont_dec;

   stopwatch_display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   stopwatch_display #(.SCAN_DIV(1)) dut_fast (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   // Edges since reset release; edge 1 is the first IDLE, every 12th a COMMIT.
   always @(posedge clk or negedge reset) begin
      if (!reset) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int an_idx(input logic [3:0] a);
      case (a)
         4'b0111: return 3;
         4'b1011: return 2;
         4'b1101: return 1;
         4'b1110: return 0;
         default: return -1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Returns just after a COMMIT edge, so the next edge is an IDLE snapshot.
   task automatic align_commit();
      bit found = 0;
      for (int i = 0; i < 14 && !found; i++) begin
         tick();
         if (edge_cnt > 0 && edge_cnt % 12 == 0) found = 1;
      end
   endtask

   // Records one full refresh starting at the first cycle an becomes 0111.
   task automatic scan_display();
      logic [3:0] prev;
      int idx;
      bit synced = 0;
      scan_ok = 1;
      for (int k = 0; k < 4; k++) begin
         scan_seg[k]  = 7'bx;
         scan_dp[k]   = 1'bx;
         scan_hold[k] = 0;
      end
      for (int i = 0; i < 6*SCAN_DIV && !synced; i++) begin
         prev = bus.an;
         tick();
         if (bus.an === 4'b0111 && prev !== 4'b0111) synced = 1;
      end
      if (!synced) scan_ok = 0;
      for (int i = 0; i < 4*SCAN_DIV; i++) begin
         idx = an_idx(bus.an);
         if (idx < 0) begin
            scan_ok = 0;
         end else begin
            scan_seg[idx]  = bus.seg;
            scan_dp[idx]   = bus.dp;
            scan_hold[idx] = scan_hold[idx] + 1;
         end
         tick();
      end
   endtask

   task automatic applyStimulus(input logic [9:0] s, input logic [3:0] d);
      bus.cont_seg = s;
      bus.cont_dec = d;
   endtask

   task automatic test_reset();
      logic [6:0] exp_seg [4];
      exp_seg = '{S0, S0, SB, SB};
      applyStimulus(10'd0, 4'd0);
      reset = 1'b0;
      wait_cycles(3);
      tests_run++;
      if ({bus.an, bus.seg, bus.dp, bus.ovf} !== {4'b1111, SB, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got an=%b seg=%b dp=%b ovf=%b, expected an=1111 seg=1111111 dp=1 ovf=0",
                  bus.an, bus.seg, bus.dp, bus.ovf);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
      tests_run++;
      if ({bus.an, bus.seg, bus.dp} !== {4'b0111, SB, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL first_edge: got an=%b seg=%b dp=%b, expected an=0111 seg=1111111 dp=1",
                  bus.an, bus.seg, bus.dp);
      end
      scan_display();
      tests_run++;
      if (scan_ok !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_scan_sync: got ok=%0d, expected 1", scan_ok);
      end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (scan_seg[k] !== exp_seg[k] || scan_dp[k] !== (k == 1 ? 1'b0 : 1'b1)
             || scan_hold[k] != SCAN_DIV) begin
            tests_failed++;
            $display("[TB] FAIL reset_digit%0d: got seg=%b dp=%b hold=%0d, expected seg=%b dp=%b hold=%0d",
                     k, scan_seg[k], scan_dp[k], scan_hold[k], exp_seg[k], (k == 1 ? 1'b0 : 1'b1), SCAN_DIV);
         end
      end
   endtask

   task automatic test_basic_123();
      logic [6:0] exp_seg [4];
      exp_seg = '{S4, S3, S2, S1};
      applyStimulus(10'd123, 4'd4);
      wait_cycles(26);
      scan_display();
      tests_run++;
      if (scan_ok !== 1'b1 || bus.ovf !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL basic_sync_ovf: got ok=%0d ovf=%b, expected ok=1 ovf=0", scan_ok, bus.ovf);
      end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (scan_seg[k] !== exp_seg[k] || scan_dp[k] !== (k == 1 ? 1'b0 : 1'b1)
             || scan_hold[k] != SCAN_DIV) begin
            tests_failed++;
            $display("[TB] FAIL basic_digit%0d: got seg=%b dp=%b hold=%0d, expected seg=%b dp=%b hold=%0d",
                     k, scan_seg[k], scan_dp[k], scan_hold[k], exp_seg[k], (k == 1 ? 1'b0 : 1'b1), SCAN_DIV);
         end
      end
   endtask

   task automatic test_overflow();
      align_commit();
      applyStimulus(10'd1000, 4'd9);
      wait_cycles(11);
      tests_run++;
      if (bus.ovf !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ovf_before_commit: got %b, expected 0", bus.ovf);
      end
      tick();
      tests_run++;
      if (bus.ovf !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ovf_at_commit: got %b, expected 1", bus.ovf);
      end
      scan_display();
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (scan_ok !== 1'b1 || scan_seg[k] !== S9 || scan_dp[k] !== (k == 1 ? 1'b0 : 1'b1)) begin
            tests_failed++;
            $display("[TB] FAIL sat_digit%0d: got ok=%0d seg=%b dp=%b, expected ok=1 seg=%b dp=%b",
                     k, scan_ok, scan_seg[k], scan_dp[k], S9, (k == 1 ? 1'b0 : 1'b1));
         end
      end
      align_commit();
      applyStimulus(10'd5, 4'd9);
      wait_cycles(11);
      tests_run++;
      if (bus.ovf !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ovf_hold: got %b, expected 1", bus.ovf);
      end
      tick();
      tests_run++;
      if (bus.ovf !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ovf_clear: got %b, expected 0", bus.ovf);
      end
   endtask

   task automatic test_blanking();
      logic [6:0] exp_a [4];
      logic [6:0] exp_b [4];
      exp_a = '{S0, S5, SB, SB};
      exp_b = '{S0, S0, S4, SB};
      applyStimulus(10'd5, 4'd0);
      wait_cycles(26);
      scan_display();
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (scan_ok !== 1'b1 || scan_seg[k] !== exp_a[k] || scan_dp[k] !== (k == 1 ? 1'b0 : 1'b1)) begin
            tests_failed++;
            $display("[TB] FAIL blank5_digit%0d: got ok=%0d seg=%b dp=%b, expected ok=1 seg=%b dp=%b",
                     k, scan_ok, scan_seg[k], scan_dp[k], exp_a[k], (k == 1 ? 1'b0 : 1'b1));
         end
      end
      applyStimulus(10'd40, 4'd0);
      wait_cycles(26);
      scan_display();
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (scan_ok !== 1'b1 || scan_seg[k] !== exp_b[k]) begin
            tests_failed++;
            $display("[TB] FAIL blank40_digit%0d: got ok=%0d seg=%b, expected ok=1 seg=%b",
                     k, scan_ok, scan_seg[k], exp_b[k]);
         end
      end
   endtask

   task automatic test_tenths_dash();
      logic [6:0] exp_seg [4];
      exp_seg = '{SD, S0, S0, S1};
      applyStimulus(10'd100, 4'd12);
      wait_cycles(26);
      scan_display();
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (scan_ok !== 1'b1 || scan_seg[k] !== exp_seg[k]) begin
            tests_failed++;
            $display("[TB] FAIL dash_digit%0d: got ok=%0d seg=%b, expected ok=1 seg=%b",
                     k, scan_ok, scan_seg[k], exp_seg[k]);
         end
      end
   endtask

   // Input change mid-conversion: the current COMMIT still shows 123.1,
   // the following one shows 456.1. Checked every cycle of both windows.
   task automatic test_back_to_back();
      logic [6:0] exp_a [4];
      logic [6:0] exp_b [4];
      int idx;
      exp_a = '{S1, S3, S2, S1};
      exp_b = '{S1, S6, S5, S4};
      align_commit();
      applyStimulus(10'd123, 4'd1);
      wait_cycles(3);
      applyStimulus(10'd456, 4'd1);
      wait_cycles(9);
      for (int c = 0; c < 24; c++) begin
         tick();
         idx = an_idx(bus.an);
         tests_run++;
         if (idx < 0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_an c%0d: got an=%b, expected one-hot low", c, bus.an);
         end else if (bus.seg !== (c < 12 ? exp_a[idx] : exp_b[idx])
                      || bus.dp !== (idx == 1 ? 1'b0 : 1'b1)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_seg c%0d: got seg=%b dp=%b, expected seg=%b dp=%b", c, bus.seg, bus.dp,
                     (c < 12 ? exp_a[idx] : exp_b[idx]), (idx == 1 ? 1'b0 : 1'b1));
         end
      end
   endtask

   task automatic test_reset_mid_conv();
      logic [6:0] exp_a [4];
      logic [6:0] exp_b [4];
      int idx;
      exp_a = '{S0, S0, SB, SB};
      exp_b = '{S7, S9, S8, S7};
      align_commit();
      applyStimulus(10'd789, 4'd7);
      wait_cycles(4);
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if ({bus.an, bus.seg, bus.dp, bus.ovf} !== {4'b1111, SB, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL midconv_reset: got an=%b seg=%b dp=%b ovf=%b, expected 1111 1111111 1 0",
                  bus.an, bus.seg, bus.dp, bus.ovf);
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 24; c++) begin
         tick();
         idx = an_idx(bus.an);
         tests_run++;
         if (idx < 0 || (c == 0 && idx != 3)) begin
            tests_failed++;
            $display("[TB] FAIL midconv_an c%0d: got an=%b, expected one-hot low (0111 first)", c, bus.an);
         end else if (bus.seg !== (c < 12 ? exp_a[idx] : exp_b[idx])) begin
            tests_failed++;
            $display("[TB] FAIL midconv_seg c%0d: got seg=%b, expected seg=%b", c, bus.seg,
                     (c < 12 ? exp_a[idx] : exp_b[idx]));
         end
      end
   endtask

   task automatic test_scan_div1();
      logic [3:0] seq [4];
      bit synced = 0;
      seq = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
      for (int i = 0; i < 6 && !synced; i++) begin
         tick();
         if (bus1.an === 4'b0111) synced = 1;
      end
      tests_run++;
      if (!synced) begin
         tests_failed++;
         $display("[TB] FAIL div1_sync: got an=%b, expected 0111 within 6 cycles", bus1.an);
      end
      for (int i = 1; i <= 8; i++) begin
         tick();
         tests_run++;
         if (bus1.an !== seq[i % 4]) begin
            tests_failed++;
            $display("[TB] FAIL div1_an%0d: got %b, expected %b", i, bus1.an, seq[i % 4]);
         end
      end
   endtask

   task automatic checkOutput();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
   endtask

   initial begin
      applyStimulus(10'd0, 4'd0);
      test_reset();
      test_basic_123();
      test_overflow();
      test_blanking();
      test_tenths_dash();
      test_back_to_back();
      test_reset_mid_conv();
      test_scan_div1();
      checkOutput();
      $finish;
   end

endmodule
